clken_gen: RTL and testbench

Parametrised synchronous clock-enable generator producing NCH independent, runtime-programmable rate strobes from the single system clock. It replaces ripple-clocked division in the synth datapath: modulation, sample, filter and ADSR logic all run on `clk` and qualify their updates with `stb[i]`. A per-channel divisor can be reprogrammed glitch-free through a valid/ready port, and all channels can be phase-aligned with a synchronous restart.

---
 rtl/clken_pkg.sv | 14 +
 rtl/clken_chan.sv | 64 ++++++
 rtl/clken_gen.sv | 58 +++++
 tb/tb_clken_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/clken_pkg.sv
// Shared defaults and types for the clock-enable generator.
package clken_pkg;

    localparam int NCH_DEF = 4;
    localparam int CW_DEF  = 20;

    // Divisor value, encoded as period-1.
    typedef logic [CW_DEF-1:0] div_t;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clken_chan.sv
// One strobe channel: down-to-wrap period counter with active/shadow divisor.
module clken_chan #(
    parameter int            CW       = 20,
    parameter logic [CW-1:0] DIV_INIT = '0
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          en,
    input  logic          sync,
    input  logic          wr,
    input  logic [CW-1:0] wr_div,
    output logic          stb,
    output logic          tgl,
    output logic          pend
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] div;
    logic [CW-1:0] shadow;
    logic          wrap;
    logic          apply;

    assign wrap  = (cnt == div);
    // The shadow is only adopted at a period boundary, so a period never changes length mid-way.
    assign apply = pend && (sync || (en && wrap));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt    <= '0;
            div    <= DIV_INIT;
            shadow <= DIV_INIT;
            pend   <= 1'b0;
            stb    <= 1'b0;
            tgl    <= 1'b0;
        end else begin
            if (sync) begin
                cnt <= '0;
                stb <= 1'b0;
                tgl <= 1'b0;
            end else if (en && wrap) begin
                cnt <= '0;
                stb <= 1'b1;
                tgl <= ~tgl;
            end else if (en) begin
                cnt <= cnt + CW'(1);
                stb <= 1'b0;
            end else begin
                stb <= 1'b0;
            end

            if (apply) begin
                div  <= shadow;
                pend <= 1'b0;
            end

            // wr is only granted while pend is clear, so it never collides with apply.
            if (wr) begin
                shadow <= wr_div;
                pend   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clken_gen.sv
// NCH independent programmable clock-enable strobes derived from clk, with
// valid/ready divisor writes and a synchronous phase-aligning restart.
module clken_gen
    import clken_pkg::*;
#(
    parameter int                NCH      = NCH_DEF,
    parameter int                CW       = CW_DEF,
    parameter logic [NCH*CW-1:0] DIV_INIT = '0,
    localparam int               CHW      = chan_w(NCH)
) (
    input  logic           clk,
    input  logic           arst,
    input  logic           en,
    input  logic           sync,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    output logic [NCH-1:0] stb,
    output logic [NCH-1:0] tgl,
    output logic [NCH-1:0] pend
);

    logic [NCH-1:0] wr;

    // Out-of-range channel indices match nothing and so stay ready; their writes are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                cfg_ready = ~pend[i];
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_ch
            assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CHW'(i));

            clken_chan #(
                .CW       (CW),
                .DIV_INIT (DIV_INIT[i*CW +: CW])
            ) u_chan (
                .clk    (clk),
                .arst   (arst),
                .en     (en),
                .sync   (sync),
                .wr     (wr[i]),
                .wr_div (cfg_div),
                .stb    (stb[i]),
                .tgl    (tgl[i]),
                .pend   (pend[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clken_gen.sv
// Directed bench for clken_gen: five channels so an out-of-range index (5) is representable.
module tb_clken_gen;

    localparam int NCH = 5;
    localparam int CW  = 8;
    localparam int CHW = 3;
    // ch4..ch0 periods-1: 1, 4, 2, 3, 0
    localparam logic [NCH*CW-1:0] DIV_INIT = {8'd1, 8'd4, 8'd2, 8'd3, 8'd0};

    logic           clk;
    logic           arst;
    logic           en;
    logic           sync;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic [NCH-1:0] stb;
    logic [NCH-1:0] tgl;
    logic [NCH-1:0] pend;

    int total = 0;
    int bad   = 0;

    clken_gen #(
        .NCH      (NCH),
        .CW       (CW),
        .DIV_INIT (DIV_INIT)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .stb       (stb),
        .tgl       (tgl),
        .pend      (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected stb vectors for edges 36..43 after the sync at edge 35.
    logic [NCH-1:0] sync_tab [8] = '{5'b00001, 5'b10001, 5'b00001, 5'b00011,
                                     5'b10001, 5'b00101, 5'b00001, 5'b11011};
    // Expected stb vectors for edges 1..5 after a reset release with en high.
    logic [NCH-1:0] rst_tab [5] = '{5'b00001, 5'b10001, 5'b00101, 5'b10011, 5'b01001};

    initial begin
        arst      = 1'b1;
        en        = 1'b0;
        sync      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        step();
        step();
        check_val("rst_stb", stb, 0);
        check_val("rst_tgl", tgl, 0);
        check_val("rst_pend", pend, 0);
        check_val("rst_ready", cfg_ready, 1);
        arst = 1'b0;
        en   = 1'b1;

        // Edges 1..12: ch1 period 4, reprogrammed to period 2 at edge 6.
        for (int k = 1; k <= 12; k++) begin
            if (k == 6) begin
                cfg_ch    = 3'd1;
                cfg_div   = 8'd1;
                cfg_valid = 1'b1;
                check_val("wr1_ready", cfg_ready, 1);
            end
            step();
            if (k == 6) begin
                cfg_valid = 1'b0;
                check_val("wr1_pend", pend[1], 1);
                check_val("wr1_busy", cfg_ready, 0);
            end
            if (k == 4) check_val("tgl1_first", tgl[1], 1);
            if (k == 7) check_val("pend1_hold", pend[1], 1);
            if (k == 8) check_val("pend1_clr", pend[1], 0);
            check_val("stb1_seq", stb[1], (k == 4 || k == 8 || k == 10 || k == 12));
            check_val("stb0_div0", stb[0], 1);
        end
        check_val("tgl1_e12", tgl[1], 0);

        // Edge 13: ch2 write div 5; edge 14: second write refused while pending.
        cfg_ch    = 3'd2;
        cfg_div   = 8'd5;
        cfg_valid = 1'b1;
        check_val("wr2_ready", cfg_ready, 1);
        step();
        check_val("wr2_pend", pend[2], 1);
        cfg_div = 8'd0;
        check_val("wr2_busy", cfg_ready, 0);
        step();
        cfg_valid = 1'b0;
        step();
        check_val("stb2_e15", stb[2], 1);
        check_val("pend2_clr", pend[2], 0);

        // Edge 16: write to nonexistent channel 5.
        cfg_ch    = 3'd5;
        cfg_div   = 8'd0;
        cfg_valid = 1'b1;
        check_val("oor_ready", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        check_val("oor_pend", pend, 0);
        check_val("stb2_e16", stb[2], 0);
        for (int k = 17; k <= 21; k++) begin
            step();
            check_val("stb2_div5", stb[2], (k == 21));
        end

        // Edge 22: ch1 back to div 3 at its own wrap edge; applies at the following wrap (24).
        cfg_ch    = 3'd1;
        cfg_div   = 8'd3;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check_val("wr1b_pend", pend[1], 1);
        check_val("stb1_e22", stb[1], 1);
        step();
        check_val("stb1_e23", stb[1], 0);
        step();
        check_val("stb1_e24", stb[1], 1);
        check_val("pend1b_clr", pend[1], 0);
        step();
        step();
        check_val("stb1_e26", stb[1], 0);

        // Edges 27..31: en low, everything holds.
        en = 1'b0;
        for (int k = 27; k <= 31; k++) begin
            step();
            check_val("hold_stb", stb, 0);
            check_val("hold_tgl1", tgl[1], 0);
        end
        en = 1'b1;
        step();
        check_val("stb1_e32", stb[1], 0);
        step();
        check_val("stb1_e33", stb[1], 1);
        check_val("tgl1_e33", tgl[1], 1);

        // Edge 34: ch3 pending div 7; edge 35: sync with a simultaneous ch4 write.
        cfg_ch    = 3'd3;
        cfg_div   = 8'd7;
        cfg_valid = 1'b1;
        step();
        check_val("wr3_pend", pend[3], 1);
        sync    = 1'b1;
        cfg_ch  = 3'd4;
        cfg_div = 8'd2;
        check_val("wr4_ready", cfg_ready, 1);
        step();
        sync      = 1'b0;
        cfg_valid = 1'b0;
        check_val("sync_stb", stb, 0);
        check_val("sync_tgl", tgl, 0);
        check_val("sync_pend", pend, 5'b10000);
        for (int k = 0; k < 8; k++) begin
            step();
            check_val("sync_stb_seq", stb, sync_tab[k]);
            if (k == 1) check_val("pend4_clr", pend, 0);
        end

        // Edge 44: pending ch2 write, then async reset mid-cycle.
        cfg_ch    = 3'd2;
        cfg_div   = 8'd0;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check_val("wr2b_pend", pend, 5'b00100);
        #2 arst = 1'b1;
        #1;
        check_val("arst_stb", stb, 0);
        check_val("arst_tgl", tgl, 0);
        check_val("arst_pend", pend, 0);
        check_val("arst_ready", cfg_ready, 1);
        #2 arst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("arst_stb_seq", stb, rst_tab[k]);
            if (k == 3) check_val("arst_tgl_e4", tgl, 5'b00110);
        end
        check_val("arst_pend_end", pend, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
